// File: rtl/cv32e41p_apu_disp_tracker.sv
// ----------------------------------------------------------------------------
// cv32e41p_apu_disp_tracker
//
// Issues APU requests from the ID stage and tracks up to DEPTH outstanding
// multicycle results. Results return in issue order, so a circular FIFO of
// destination addresses is enough to route each returning result to its
// write-back register. The block also reports RAW/WAW hazards against
// in-flight destinations, plus stall and performance-event information.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   enable_i, apu_lat_i,          op presented by ID: valid, latency class,
//   apu_waddr_i                   destination register
//   flush_i                       drop every outstanding entry
//   is_decoding_i                 qualifies the dependency outputs
//   read_regs_i/_valid_i          operand addresses checked for RAW hazards
//   write_regs_i/_valid_i         destination addresses checked for WAW hazards
//   apu_req_o, apu_gnt_i          request/grant handshake to the interconnect
//   apu_rvalid_i                  in-order result valid from the interconnect
//   apu_waddr_o, apu_wvalid_o     write-back address/valid of returning result
//   read_dep_o, write_dep_o       RAW / WAW hazard
//   stall_o, perf_type_o,         stall and its latency-order / no-grant
//   perf_cont_o                   components
//   count_o                       number of outstanding entries
//   active_o, apu_multicycle_o,   status flags
//   apu_singlecycle_o, spurious_o
// ----------------------------------------------------------------------------
module cv32e41p_apu_disp_tracker #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned N_RD   = 3,
   parameter int unsigned N_WR   = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic [1:0]               apu_lat_i,
   input  logic [ADDR_W-1:0]        apu_waddr_i,
   input  logic                     flush_i,
   input  logic                     is_decoding_i,
   input  logic [N_RD*ADDR_W-1:0]   read_regs_i,
   input  logic [N_RD-1:0]          read_regs_valid_i,
   input  logic [N_WR*ADDR_W-1:0]   write_regs_i,
   input  logic [N_WR-1:0]          write_regs_valid_i,
   output logic                     apu_req_o,
   input  logic                     apu_gnt_i,
   input  logic                     apu_rvalid_i,
   output logic [ADDR_W-1:0]        apu_waddr_o,
   output logic                     apu_wvalid_o,
   output logic                     read_dep_o,
   output logic                     write_dep_o,
   output logic                     stall_o,
   output logic                     perf_type_o,
   output logic                     perf_cont_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                     active_o,
   output logic                     apu_multicycle_o,
   output logic                     apu_singlecycle_o,
   output logic                     spurious_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] fifo_q [DEPTH];
   logic [ADDR_W-1:0] fifo_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [1:0]        last_lat_q, last_lat_d;
   logic              spurious_q, spurious_d;

   logic active_s, stall_full_s, stall_type_s, stall_nack_s;
   logic valid_req_s, returned_req_s, push_s, pop_s, spurious_evt_s;
   logic rd_hit_s, wr_hit_s;

   // Issue/handshake decode from presented op and registered occupancy
   always_comb begin
      active_s       = (count_q != {CNT_W{1'b0}});
      stall_full_s   = (count_q == FULL_CNT);
      // A shorter-latency op could return before an in-flight one, and a
      // latency-3 op has no bounded return slot: both must wait for drain.
      stall_type_s   = enable_i & active_s &
                       ((apu_lat_i < last_lat_q) | (apu_lat_i == 2'd3));
      valid_req_s    = enable_i & ~stall_full_s & ~stall_type_s;
      stall_nack_s   = valid_req_s & ~apu_gnt_i;
      // Result arriving together with its own request while nothing is
      // outstanding belongs to this op and bypasses the FIFO.
      returned_req_s = valid_req_s & apu_rvalid_i & ~active_s;
      push_s         = valid_req_s & apu_gnt_i & ~returned_req_s;
      pop_s          = apu_rvalid_i & active_s;
      spurious_evt_s = apu_rvalid_i & ~active_s & ~valid_req_s;
   end

   // Next-state computation for FIFO, pointers, count and sticky flags
   always_comb begin
      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (valid_req_s) begin
         last_lat_d = apu_lat_i;
      end else begin
         last_lat_d = last_lat_q;
      end
      if (spurious_evt_s) begin
         spurious_d = 1'b1;
      end else begin
         spurious_d = spurious_q;
      end
      if (flush_i) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         // DEPTH is a power of two, so pointer wrap is plain overflow
         if (push_s) begin
            fifo_d[wr_ptr_q] = apu_waddr_i;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + {{(CNT_W-1){1'b0}}, push_s}
                           - {{(CNT_W-1){1'b0}}, pop_s};
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= {ADDR_W{1'b0}};
         end
         wr_ptr_q   <= {PTR_W{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
         count_q    <= {CNT_W{1'b0}};
         last_lat_q <= 2'd0;
         spurious_q <= 1'b0;
      end else begin
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         last_lat_q <= last_lat_d;
         spurious_q <= spurious_d;
      end
   end

   // Hazard search over live entries; the head is excluded while it pops
   // because its write-back completes this cycle.
   always_comb begin
      rd_hit_s = 1'b0;
      wr_hit_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PTR_W-1:0] offs;
         logic             live;
         offs = PTR_W'(i) - rd_ptr_q;
         live = (CNT_W'(offs) < count_q) & ~(pop_s & (offs == {PTR_W{1'b0}}));
         for (int r = 0; r < N_RD; r++) begin
            if (live && read_regs_valid_i[r] &&
                (read_regs_i[r*ADDR_W +: ADDR_W] == fifo_q[i])) begin
               rd_hit_s = 1'b1;
            end else begin
               rd_hit_s = rd_hit_s;
            end
         end
         for (int w = 0; w < N_WR; w++) begin
            if (live && write_regs_valid_i[w] &&
                (write_regs_i[w*ADDR_W +: ADDR_W] == fifo_q[i])) begin
               wr_hit_s = 1'b1;
            end else begin
               wr_hit_s = wr_hit_s;
            end
         end
      end
      // The op being issued right now is not yet in the FIFO
      if (valid_req_s && !returned_req_s) begin
         for (int r = 0; r < N_RD; r++) begin
            if (read_regs_valid_i[r] && (read_regs_i[r*ADDR_W +: ADDR_W] == apu_waddr_i)) begin
               rd_hit_s = 1'b1;
            end else begin
               rd_hit_s = rd_hit_s;
            end
         end
         for (int w = 0; w < N_WR; w++) begin
            if (write_regs_valid_i[w] && (write_regs_i[w*ADDR_W +: ADDR_W] == apu_waddr_i)) begin
               wr_hit_s = 1'b1;
            end else begin
               wr_hit_s = wr_hit_s;
            end
         end
      end else begin
         rd_hit_s = rd_hit_s;
      end
   end

   // Output drive
   always_comb begin
      if (pop_s) begin
         apu_waddr_o = fifo_q[rd_ptr_q];
      end else if (returned_req_s) begin
         apu_waddr_o = apu_waddr_i;
      end else begin
         apu_waddr_o = {ADDR_W{1'b0}};
      end
      apu_wvalid_o      = pop_s | returned_req_s;
      apu_req_o         = valid_req_s;
      read_dep_o        = is_decoding_i & rd_hit_s;
      write_dep_o       = is_decoding_i & wr_hit_s;
      stall_o           = stall_full_s | stall_type_s | stall_nack_s;
      perf_type_o       = stall_type_s;
      perf_cont_o       = stall_nack_s;
      count_o           = count_q;
      active_o          = active_s;
      apu_singlecycle_o = ~active_s;
      apu_multicycle_o  = (last_lat_q == 2'd3);
      spurious_o        = spurious_q;
   end

endmodule

// File: tb/tb_cv32e41p_apu_disp_tracker.sv
module tb_cv32e41p_apu_disp_tracker;

   logic clk = 1'b0;
   logic rst = 1'b1, en = 1'b0, fl = 1'b0, dec = 1'b0, gnt = 1'b0, rv = 1'b0;
   logic [1:0]  lat = 2'd0;
   logic [5:0]  wa = 6'd0;
   logic [17:0] rregs = 18'd0;
   logic [2:0]  rvld = 3'd0;
   logic [11:0] wregs = 12'd0;
   logic [1:0]  wvld = 2'd0;

   logic        req_o, wvalid_o, rdep_o, wdep_o, stall_o, ptype_o, pcont_o;
   logic        active_o, multi_o, single_o, spur_o;
   logic [5:0]  waddr_o;
   logic [2:0]  count_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cv32e41p_apu_disp_tracker dut (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .apu_lat_i(lat), .apu_waddr_i(wa),
      .flush_i(fl), .is_decoding_i(dec),
      .read_regs_i(rregs), .read_regs_valid_i(rvld),
      .write_regs_i(wregs), .write_regs_valid_i(wvld),
      .apu_req_o(req_o), .apu_gnt_i(gnt), .apu_rvalid_i(rv),
      .apu_waddr_o(waddr_o), .apu_wvalid_o(wvalid_o),
      .read_dep_o(rdep_o), .write_dep_o(wdep_o), .stall_o(stall_o),
      .perf_type_o(ptype_o), .perf_cont_o(pcont_o), .count_o(count_o),
      .active_o(active_o), .apu_multicycle_o(multi_o),
      .apu_singlecycle_o(single_o), .spurious_o(spur_o)
   );

   // ---------------- reference model (queue of in-flight destinations) ----
   logic [5:0] mq[$];
   int  m_ll = 0;
   bit  m_sp = 0;
   bit  e_vreq, e_ret, e_pop, e_stype, e_nack, e_full, e_rdep, e_wdep;
   int  e_waddr;

   task automatic model_eval();
      logic [5:0] live[$];
      int cnt = mq.size();
      e_full  = (cnt == 4);
      e_stype = en && cnt != 0 && (int'(lat) < m_ll || lat == 2'd3);
      e_vreq  = en && !e_full && !e_stype;
      e_nack  = e_vreq && !gnt;
      e_ret   = e_vreq && rv && cnt == 0;
      e_pop   = rv && cnt != 0;
      e_waddr = e_pop ? int'(mq[0]) : (e_ret ? int'(wa) : 0);
      live = mq;
      if (e_pop) void'(live.pop_front());
      if (e_vreq && !e_ret) live.push_back(wa);
      e_rdep = 0;
      e_wdep = 0;
      foreach (live[k]) begin
         for (int p = 0; p < 3; p++)
            if (rvld[p] && rregs[p*6 +: 6] == live[k]) e_rdep = 1;
         for (int p = 0; p < 2; p++)
            if (wvld[p] && wregs[p*6 +: 6] == live[k]) e_wdep = 1;
      end
      e_rdep = e_rdep && dec;
      e_wdep = e_wdep && dec;
   endtask

   task automatic model_update();
      if (rst) begin
         mq.delete();
         m_ll = 0;
         m_sp = 0;
      end else begin
         if (rv && mq.size() == 0 && !e_vreq) m_sp = 1;
         if (e_vreq) m_ll = int'(lat);
         if (fl) mq.delete();
         else begin
            if (e_pop) void'(mq.pop_front());
            if (e_vreq && gnt && !e_ret) mq.push_back(wa);
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive current inputs (already set), settle, compare every output to model
   task automatic check_model(input string tag);
      #1;
      model_eval();
      chk({tag, ".req"},    int'(req_o),    int'(e_vreq));
      chk({tag, ".wvalid"}, int'(wvalid_o), int'(e_pop || e_ret));
      chk({tag, ".waddr"},  int'(waddr_o),  e_waddr);
      chk({tag, ".rdep"},   int'(rdep_o),   int'(e_rdep));
      chk({tag, ".wdep"},   int'(wdep_o),   int'(e_wdep));
      chk({tag, ".stall"},  int'(stall_o),  int'(e_full || e_stype || e_nack));
      chk({tag, ".ptype"},  int'(ptype_o),  int'(e_stype));
      chk({tag, ".pcont"},  int'(pcont_o),  int'(e_nack));
      chk({tag, ".count"},  int'(count_o),  mq.size());
      chk({tag, ".active"}, int'(active_o), int'(mq.size() != 0));
      chk({tag, ".single"}, int'(single_o), int'(mq.size() == 0));
      chk({tag, ".multi"},  int'(multi_o),  int'(m_ll == 3));
      chk({tag, ".spur"},   int'(spur_o),   int'(m_sp));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic set_in(input logic r, input logic e, input logic [1:0] l,
                         input logic [5:0] a, input logic g, input logic v, input logic f);
      rst = r; en = e; lat = l; wa = a; gnt = g; rv = v; fl = f;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       rst, en;
      logic [1:0] lat;
      logic [5:0] wa;
      logic       gnt, rv, fl;
      logic       e_req, e_wv;
      logic [5:0] e_wa;
      logic       e_stall;
      logic [2:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   initial begin
      //                rst   en    lat   wa     gnt   rv    fl    req   wv    wa_o   stall cnt
      vecs.push_back('{1'b1, 1'b0, 2'd0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 3'd0});
      vecs.push_back('{1'b0, 1'b1, 2'd0, 6'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd5,  1'b0, 3'd0});
      vecs.push_back('{1'b0, 1'b0, 2'd0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 3'd0});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 6'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 3'd0});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 6'd2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 3'd1});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 6'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 3'd2});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 6'd4,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 3'd3});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 3'd4});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 6'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1,  1'b1, 3'd4});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 6'd6,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd2,  1'b0, 3'd3});
      vecs.push_back('{1'b0, 1'b1, 2'd2, 6'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd3,  1'b0, 3'd3});
      vecs.push_back('{1'b0, 1'b0, 2'd0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd4,  1'b0, 3'd3});
      vecs.push_back('{1'b0, 1'b0, 2'd0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd6,  1'b0, 3'd2});
      vecs.push_back('{1'b0, 1'b0, 2'd0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd7,  1'b0, 3'd1});
      vecs.push_back('{1'b0, 1'b0, 2'd0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 3'd0});

      @(negedge clk);
      foreach (vecs[i]) begin
         set_in(vecs[i].rst, vecs[i].en, vecs[i].lat, vecs[i].wa,
                vecs[i].gnt, vecs[i].rv, vecs[i].fl);
         check_model($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.t_req", i),   int'(req_o),    int'(vecs[i].e_req));
         chk($sformatf("vec%0d.t_wv", i),    int'(wvalid_o), int'(vecs[i].e_wv));
         chk($sformatf("vec%0d.t_waddr", i), int'(waddr_o),  int'(vecs[i].e_wa));
         chk($sformatf("vec%0d.t_stall", i), int'(stall_o),  int'(vecs[i].e_stall));
         chk($sformatf("vec%0d.t_count", i), int'(count_o),  int'(vecs[i].e_cnt));
         if (i == 0) chk("reset.single", int'(single_o), 1);
         step();
      end

      // Latency ordering stall and no-grant stall (last_lat is 2 here)
      set_in(1'b0, 1'b1, 2'd2, 6'd9, 1'b1, 1'b0, 1'b0); check_model("lat_push"); step();
      set_in(1'b0, 1'b1, 2'd1, 6'd8, 1'b1, 1'b0, 1'b0); check_model("lat_short");
      chk("lat_short.perf_type", int'(ptype_o), 1);
      chk("lat_short.req", int'(req_o), 0);
      step();
      set_in(1'b0, 1'b1, 2'd2, 6'd8, 1'b0, 1'b0, 1'b0); check_model("nogrant");
      chk("nogrant.req", int'(req_o), 1);
      chk("nogrant.perf_cont", int'(pcont_o), 1);
      chk("nogrant.stall", int'(stall_o), 1);
      step();

      // RAW hazard on entry 7, masked while that entry pops
      set_in(1'b0, 1'b1, 2'd2, 6'd7, 1'b1, 1'b1, 1'b0); check_model("dep_push7"); step();
      set_in(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0);
      dec = 1'b1; rregs = {6'd0, 6'd7, 6'd0}; rvld = 3'b010;
      wregs = {6'd0, 6'd7}; wvld = 2'b01;
      check_model("dep_hold");
      chk("dep_hold.read_dep", int'(rdep_o), 1);
      chk("dep_hold.write_dep", int'(wdep_o), 1);
      rv = 1'b1;
      check_model("dep_pop");
      chk("dep_pop.read_dep", int'(rdep_o), 0);
      step();
      dec = 1'b0; rvld = 3'd0; wvld = 2'd0;

      // Spurious response is sticky; flush clears three entries
      set_in(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b1, 1'b0); check_model("spur_evt"); step();
      set_in(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0); check_model("spur_hold");
      chk("spur_hold.spurious", int'(spur_o), 1);
      for (int k = 0; k < 3; k++) begin
         set_in(1'b0, 1'b1, 2'd2, 6'(10 + k), 1'b1, 1'b0, 1'b0); check_model("fl_fill"); step();
      end
      set_in(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b1); check_model("flush");
      chk("flush.count_same_cycle", int'(count_o), 3);
      step();
      set_in(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0); check_model("after_flush");
      chk("after_flush.count", int'(count_o), 0);
      chk("after_flush.spurious", int'(spur_o), 1);

      // Reset in the middle of a burst
      set_in(1'b0, 1'b1, 2'd3, 6'd20, 1'b1, 1'b0, 1'b0); check_model("burst0"); step();
      set_in(1'b1, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0); check_model("burst_rst"); step();
      set_in(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0); check_model("post_rst");
      chk("post_rst.count", int'(count_o), 0);
      chk("post_rst.spurious", int'(spur_o), 0);
      chk("post_rst.multi", int'(multi_o), 0);
      chk("post_rst.single", int'(single_o), 1);
      step();

      // Randomized traffic against the queue model
      for (int c = 0; c < 600; c++) begin
         rst   = ($urandom_range(0, 63) == 0);
         en    = ($urandom_range(0, 3) != 0);
         lat   = 2'($urandom_range(0, 3));
         wa    = 6'($urandom_range(0, 7));
         gnt   = ($urandom_range(0, 4) != 0);
         rv    = ($urandom_range(0, 2) == 0);
         fl    = ($urandom_range(0, 15) == 0);
         dec   = 1'($urandom_range(0, 1));
         for (int p = 0; p < 3; p++) rregs[p*6 +: 6] = 6'($urandom_range(0, 7));
         for (int p = 0; p < 2; p++) wregs[p*6 +: 6] = 6'($urandom_range(0, 7));
         rvld  = 3'($urandom_range(0, 7));
         wvld  = 2'($urandom_range(0, 3));
         check_model($sformatf("rnd%0d", c));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
